avg_pool_core_scheduler: RTL
============================

Name: avg_pool_core_scheduler

Overview:
- Sequences a bank of NUM_CORES average-pool cores (2x2, stride 2, fp16) over all channel maps of one pooling layer (AVG1/AVG2/AVG3).
- On a start pulse it latches the layer state and channel count, then dispatches channels in batches of NUM_CORES. Each active core gets an enable window of exactly input_size*input_size cycles, followed by a pipeline drain.
- Sits between the top-level layer FSM and the pool-core array. It drives each core's enable and the batch channel base used by the BRAM bank-select logic.

Parameters:
- NUM_CORES, 4, number of pool cores driven in parallel
- STATE_DATAWIDTH, 4, width of layer state code
- AVG1_STATE, 3; AVG2_STATE, 6; AVG3_STATE, 9: layer state codes
- AVG1_INPUT_SIZE, 80; AVG2_INPUT_SIZE, 36; AVG3_INPUT_SIZE, 14: input map side length
- CHANNEL_DATAWIDTH, 8, width of channel count and base
- CYCLE_DATAWIDTH, 13, width of per-map cycle counter (6400 < 8192)
- DRAIN_CYCLES, 3, enable-low cycles after each batch (address, data, last_clock/wr_ena pipeline)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to pool a layer; sampled only in IDLE
- state  in  STATE_DATAWIDTH  layer code, sampled with start
- num_channels  in  CHANNEL_DATAWIDTH  channel maps in layer, sampled with start
- core_enable  out  NUM_CORES  per-core enable, registered
- batch_channel_base  out  CHANNEL_DATAWIDTH  channel index handled by core 0 in current batch
- busy  out  1  high from first cycle after accepted start through the done cycle
- done  out  1  one-cycle pulse, layer complete
- err_bad_state  out  1  one-cycle pulse, start with unsupported state

Behaviour:
- Reset (async, active-low, any state): FSM=IDLE; core_enable=0, batch_channel_base=0, busy=0, done=0, err_bad_state=0; counters=0. A reset mid-RUN drops enables in the same instant, so cores return to address 0.
- All outputs are registered. A start accepted at cycle t produces its first visible effect at t+1.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start, decode state.
  - Unsupported code: err_bad_state=1 at t+1, remain IDLE, busy stays 0.
  - num_channels==0: go DONE (done=1, busy=1 at t+1).
  - Otherwise: latch map_cycles=size*size (6400/1296/196); remaining=num_channels; base=0; go RUN.
- RUN:
  - core_enable[i]=1 for i < min(remaining, NUM_CORES), else 0.
  - Held exactly map_cycles cycles, counted with cyc_cnt from 0 to map_cycles-1.
  - Then go DRAIN with all enables 0.
- DRAIN:
  - Exactly DRAIN_CYCLES cycles with enables 0. This guarantees each core sees enable low at least 1 cycle and resets its address.
  - Then, if remaining > NUM_CORES: remaining -= NUM_CORES, base += NUM_CORES, go RUN. The new base is visible in the first cycle of the new RUN.
  - Else go DONE.
- DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0.
- start outside IDLE is ignored; no queueing. state and num_channels are ignored after sampling.
- Per-batch period = map_cycles + DRAIN_CYCLES. Layer latency from start to done = 1 + ceil(C/NUM_CORES)*(map_cycles+DRAIN_CYCLES) cycles.
- Arithmetic is unsigned. size*size is computed at CYCLE_DATAWIDTH width. batch_channel_base never exceeds num_channels-1.

Decomposition:
- Shared package avg_pool_pkg:
  - AVG*_STATE codes, AVG*_INPUT_SIZE and AVG*_OUTPUT_SIZE constants.
  - FSM state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3).
  - DRAIN_CYCLES default.
- One combinational sub-module, avg_pool_size_lut: maps state to {input_size, map_cycles, valid}. Reused by the pool cores' size decode.

Test Plan:
- AVG3 (state=9), num_channels=4, start at cycle 0 -> core_enable=4'b1111 cycles 1..196, 0 cycles 197..199, base=0, done pulse cycle 200, busy 1..200.
- AVG3, num_channels=6 -> batch1 4'b1111 cycles 1..196, base=0; drain 197..199; batch2 4'b0011 cycles 200..395, base=4; done cycle 399.
- AVG1 (state=3), num_channels=1 -> core_enable=4'b0001 cycles 1..6400; done cycle 6404. Confirms 13-bit counter reaches 6399 without wrap.
- state=5 with start -> err_bad_state=1 cycle 1 only; busy, core_enable, done stay 0. num_channels=0 with state=6 -> done=1 cycle 1, no enable ever.
- start re-pulsed during RUN of AVG2 -> ignored, timing identical to single start. Reset asserted at cycle 500 of AVG2 run -> core_enable=0 immediately; after release, IDLE, next start works normally.

Source files
------------

// File: rtl/avg_pool_pkg.sv
// Shared constants for the average-pool layer sequencing: layer state codes,
// map geometry for each pooling layer and the scheduler FSM encoding.
package avg_pool_pkg;

  localparam int AVG1_STATE = 3;
  localparam int AVG2_STATE = 6;
  localparam int AVG3_STATE = 9;

  localparam int AVG1_INPUT_SIZE = 80;
  localparam int AVG2_INPUT_SIZE = 36;
  localparam int AVG3_INPUT_SIZE = 14;

  // 2x2 window, stride 2
  localparam int AVG1_OUTPUT_SIZE = AVG1_INPUT_SIZE / 2;
  localparam int AVG2_OUTPUT_SIZE = AVG2_INPUT_SIZE / 2;
  localparam int AVG3_OUTPUT_SIZE = AVG3_INPUT_SIZE / 2;

  // Wide enough for the largest input side (80)
  localparam int SIZE_DATAWIDTH = 7;

  // Enable-low cycles after a batch: address, data and last_clock/wr_ena stages
  localparam int DRAIN_CYCLES_DEFAULT = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/avg_pool_size_lut.sv
// Layer state code -> input map side, cycles per map and a supported flag.
// Shared with the pool cores so both sides agree on map geometry.
module avg_pool_size_lut
  import avg_pool_pkg::*;
#(
  parameter int STATE_DATAWIDTH = 4,
  parameter int CYCLE_DATAWIDTH = 13
) (
  input  logic [STATE_DATAWIDTH-1:0] state,
  output logic [SIZE_DATAWIDTH-1:0]  input_size,
  output logic [CYCLE_DATAWIDTH-1:0] map_cycles,
  output logic                       valid
);

  // Decode the layer code; map_cycles is side*side at counter width
  always_comb begin
    input_size = '0;
    valid      = 1'b0;
    if (state == STATE_DATAWIDTH'(AVG1_STATE)) begin
      input_size = SIZE_DATAWIDTH'(AVG1_INPUT_SIZE);
      valid      = 1'b1;
    end else if (state == STATE_DATAWIDTH'(AVG2_STATE)) begin
      input_size = SIZE_DATAWIDTH'(AVG2_INPUT_SIZE);
      valid      = 1'b1;
    end else if (state == STATE_DATAWIDTH'(AVG3_STATE)) begin
      input_size = SIZE_DATAWIDTH'(AVG3_INPUT_SIZE);
      valid      = 1'b1;
    end
    map_cycles = CYCLE_DATAWIDTH'(input_size) * CYCLE_DATAWIDTH'(input_size);
  end

endmodule

// File: rtl/avg_pool_core_scheduler.sv
// Dispatches the channel maps of one pooling layer to a bank of pool cores,
// NUM_CORES channels at a time. Each batch gets an enable window of one full
// map followed by a short enable-low drain so every core resets its address.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for start; decodes layer code and channel count
//   S_RUN   | active cores enabled for map_cycles cycles
//   S_DRAIN | all enables low for DRAIN_CYCLES cycles, pipeline flush
//   S_DONE  | one-cycle done pulse, busy still high
module avg_pool_core_scheduler
  import avg_pool_pkg::*;
#(
  parameter int NUM_CORES         = 4,
  parameter int STATE_DATAWIDTH   = 4,
  parameter int CHANNEL_DATAWIDTH = 8,
  parameter int CYCLE_DATAWIDTH   = 13,
  parameter int DRAIN_CYCLES      = DRAIN_CYCLES_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [STATE_DATAWIDTH-1:0]   state,
  input  logic [CHANNEL_DATAWIDTH-1:0] num_channels,
  output logic [NUM_CORES-1:0]         core_enable,
  output logic [CHANNEL_DATAWIDTH-1:0] batch_channel_base,
  output logic                         busy,
  output logic                         done,
  output logic                         err_bad_state
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CHANNEL_DATAWIDTH-1:0] CORES_C = CHANNEL_DATAWIDTH'(NUM_CORES);

  sched_state_t                 fsm;
  logic [CYCLE_DATAWIDTH-1:0]   map_cycles_q;
  logic [CYCLE_DATAWIDTH-1:0]   cyc_cnt;
  logic [DRAIN_W-1:0]           drain_cnt;
  logic [CHANNEL_DATAWIDTH-1:0] remaining;

  logic [SIZE_DATAWIDTH-1:0]    lut_size;
  logic [CYCLE_DATAWIDTH-1:0]   lut_map_cycles;
  logic                         lut_valid;
  logic                         lut_ok;

  avg_pool_size_lut #(
    .STATE_DATAWIDTH (STATE_DATAWIDTH),
    .CYCLE_DATAWIDTH (CYCLE_DATAWIDTH)
  ) u_size_lut (
    .state      (state),
    .input_size (lut_size),
    .map_cycles (lut_map_cycles),
    .valid      (lut_valid)
  );

  // A zero-sized map would never reach the RUN terminal count, so reject it too
  assign lut_ok = lut_valid & (|lut_size);

  // Cores 0..min(rem, NUM_CORES)-1 are active in a batch
  function automatic logic [NUM_CORES-1:0] batch_mask(input logic [CHANNEL_DATAWIDTH-1:0] rem);
    logic [NUM_CORES-1:0] m;
    for (int i = 0; i < NUM_CORES; i++) begin
      m[i] = (rem > CHANNEL_DATAWIDTH'(i));
    end
    return m;
  endfunction

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm                <= S_IDLE;
      map_cycles_q       <= '0;
      cyc_cnt            <= '0;
      drain_cnt          <= '0;
      remaining          <= '0;
      core_enable        <= '0;
      batch_channel_base <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err_bad_state      <= 1'b0;
    end else begin
      done          <= 1'b0;
      err_bad_state <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (start) begin
            if (!lut_ok) begin
              err_bad_state <= 1'b1;
            end else if (num_channels == '0) begin
              busy <= 1'b1;
              done <= 1'b1;
              fsm  <= S_DONE;
            end else begin
              map_cycles_q       <= lut_map_cycles;
              remaining          <= num_channels;
              batch_channel_base <= '0;
              cyc_cnt            <= '0;
              core_enable        <= batch_mask(num_channels);
              busy               <= 1'b1;
              fsm                <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (cyc_cnt == map_cycles_q - CYCLE_DATAWIDTH'(1)) begin
            core_enable <= '0;
            cyc_cnt     <= '0;
            drain_cnt   <= DRAIN_W'(DRAIN_CYCLES - 1);
            fsm         <= S_DRAIN;
          end else begin
            cyc_cnt <= cyc_cnt + CYCLE_DATAWIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            if (remaining > CORES_C) begin
              remaining          <= remaining - CORES_C;
              batch_channel_base <= batch_channel_base + CORES_C;
              core_enable        <= batch_mask(remaining - CORES_C);
              fsm                <= S_RUN;
            end else begin
              done <= 1'b1;
              fsm  <= S_DONE;
            end
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        S_DONE: begin
          busy <= 1'b0;
          fsm  <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule
